// File: rtl/mem_readout.sv
// rtl/mem_readout.sv - reads DEPTH words from a 1-cycle-latency RAM and streams them with a checksum
module mem_readout #(
   parameter int AW    = 10,
   parameter int DW    = 8,
   parameter int DEPTH = 1024,
   parameter int SUMW  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic [AW-1:0]   addr_rd,
   output logic            re,
   input  logic [DW-1:0]   rdata,
   output logic [DW-1:0]   out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
   output logic [SUMW-1:0] checksum,
   output logic            busy,
   output logic            finished
);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH-1);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nx;

   logic [AW:0]   rd_ptr;
   logic [AW:0]   beat_cnt;
   logic [AW-1:0] addr_q;
   logic          inflight;
   logic [DW-1:0] fifo_mem [2];
   logic          wr_idx;
   logic          rd_idx;
   logic [1:0]    count;
   logic          xfer;
   logic          push;
   logic          pop;

   // Words still owed to the consumer = buffered + in flight; never more than two.
   always_comb begin
      state_nx = state;
      re       = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            re = ((count + {1'b0, inflight}) < 2'd2) && (rd_ptr < DEPTH_W);
            if (xfer && out_last) state_nx = FIN;
         end
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // An empty buffer forwards the arriving read word directly, saving a cycle of latency.
   assign out_valid = (count != 2'd0) || inflight;
   assign out_data  = (count != 2'd0) ? fifo_mem[rd_idx] : (inflight ? rdata : '0);
   assign out_last  = out_valid && (beat_cnt == LAST_W);
   assign xfer      = out_valid && out_ready;
   assign pop       = xfer && (count != 2'd0);
   assign push      = inflight && !(xfer && (count == 2'd0));
   assign addr_rd   = re ? rd_ptr[AW-1:0] : addr_q;
   assign busy      = (state == RUN);
   assign finished  = (state == FIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         beat_cnt <= '0;
         addr_q   <= '0;
         inflight <= 1'b0;
         wr_idx   <= 1'b0;
         rd_idx   <= 1'b0;
         count    <= 2'd0;
         checksum <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            rd_ptr   <= '0;
            beat_cnt <= '0;
            inflight <= 1'b0;
            wr_idx   <= 1'b0;
            rd_idx   <= 1'b0;
            count    <= 2'd0;
            checksum <= '0;
         end else begin
            inflight <= re;
            if (re) begin
               rd_ptr <= rd_ptr + ONE_W;
               addr_q <= rd_ptr[AW-1:0];
            end
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (xfer) begin
               beat_cnt <= beat_cnt + ONE_W;
               checksum <= checksum + SUMW'(out_data);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_idx] <= rdata;
   end
endmodule

// File: tb/tb_mem_readout.sv
// tb/tb_mem_readout.sv - directed bench for mem_readout
module tb_mem_readout;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;
   int total = 0;
   int bad = 0;

   logic       start_a, re_a, valid_a, ready_a, last_a, busy_a, fin_a;
   logic [9:0] addr_a;
   logic [7:0] rdata_a = '0;
   logic [7:0] data_a;
   logic [15:0] sum_a;
   logic [7:0] mem_a [1024];
   logic [9:0] last_addr;

   logic       start_b, re_b, valid_b, last_b, busy_b, fin_b;
   logic [1:0] addr_b;
   logic [7:0] rdata_b = '0;
   logic [7:0] data_b;
   logic [15:0] sum_b;
   logic [7:0] mem_b [4];

   logic       start_c, re_c, valid_c, last_c, busy_c, fin_c;
   logic [1:0] addr_c;
   logic [7:0] rdata_c = '0;
   logic [7:0] data_c;
   logic [7:0] sum_c;
   logic [7:0] mem_c [4];
   logic [7:0] exp_c [4];

   mem_readout #(.AW(10), .DW(8), .DEPTH(1024), .SUMW(16)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .addr_rd(addr_a), .re(re_a),
      .rdata(rdata_a), .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a),
      .out_last(last_a), .checksum(sum_a), .busy(busy_a), .finished(fin_a));

   mem_readout #(.AW(2), .DW(8), .DEPTH(4), .SUMW(16)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .addr_rd(addr_b), .re(re_b),
      .rdata(rdata_b), .out_data(data_b), .out_valid(valid_b), .out_ready(1'b1),
      .out_last(last_b), .checksum(sum_b), .busy(busy_b), .finished(fin_b));

   mem_readout #(.AW(2), .DW(8), .DEPTH(4), .SUMW(8)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .addr_rd(addr_c), .re(re_c),
      .rdata(rdata_c), .out_data(data_c), .out_valid(valid_c), .out_ready(1'b1),
      .out_last(last_c), .checksum(sum_c), .busy(busy_c), .finished(fin_c));

   always @(posedge clk) if (re_a) rdata_a <= mem_a[addr_a];
   always @(posedge clk) if (re_b) rdata_b <= mem_b[addr_b];
   always @(posedge clk) if (re_c) rdata_c <= mem_c[addr_c];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0 full rate, 1 backpressure, 2 redundant starts, 3 reset at beat 500
   task automatic run_a(input int mode);
      int   cyc;
      int   beat;
      int   issued;
      int   pend;
      logic ready;
      logic exp_re;
      logic done;
      beat = 0; issued = 0; done = 1'b0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 1;
      while (!done && cyc < 20000) begin
         pend = issued - beat;
         if (mode == 1) ready = (cyc % 150 < 10) ? 1'b0 : 1'($urandom_range(0, 1));
         else ready = 1'b1;
         ready_a = ready;
         exp_re = (pend < 2) && (issued < 1024);
         chk("busy_run", busy_a, 1);
         chk("re_rule", re_a, exp_re);
         chk("addr_rd", addr_a, exp_re ? issued[9:0] : last_addr);
         chk("valid", valid_a, pend > 0);
         if (mode == 0) chk("full_rate", valid_a, cyc >= 2);
         if (valid_a) begin
            chk("data", data_a, (beat + 42) % 256);
            chk("last", last_a, beat == 1023);
         end
         start_a = (mode == 2 && beat == 100 && valid_a && ready);
         if (mode == 3 && beat == 500) begin
            reset = 1'b1;
            #1;
            chk("rst_valid", valid_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_re", re_a, 0);
            chk("rst_sum", sum_a, 0);
            last_addr = '0;
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         if (exp_re) begin
            last_addr = issued[9:0];
            issued++;
         end
         if (valid_a && ready) begin
            if (beat == 1023) begin
               done = 1'b1;
               if (mode == 0) chk("last_cycle", cyc, 1025);
            end
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      ready_a = 1'b1;
      chk("run_done", done, 1);
      start_a = (mode == 2);
      chk("fin_pulse", fin_a, 1);
      chk("fin_busy", busy_a, 0);
      chk("fin_valid", valid_a, 0);
      chk("checksum", sum_a, 16'hFE00);
      @(negedge clk);
      start_a = 1'b0;
      chk("fin_drop", fin_a, 0);
      chk("idle_busy", busy_a, 0);
      chk("sum_hold", sum_a, 16'hFE00);
      @(negedge clk);
      chk("still_idle", busy_a, 0);
   endtask

   initial begin
      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      ready_a = 1'b1;
      last_addr = '0;
      for (int i = 0; i < 1024; i++) mem_a[i] = 8'((i + 42) % 256);
      for (int i = 0; i < 4; i++) mem_b[i] = 8'hFF;
      exp_c[0] = 8'h80; exp_c[1] = 8'h80; exp_c[2] = 8'h01; exp_c[3] = 8'h02;
      for (int i = 0; i < 4; i++) mem_c[i] = exp_c[i];
      repeat (2) @(negedge clk);
      chk("rst_addr", addr_a, 0);
      chk("rst_re0", re_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_valid0", valid_a, 0);
      chk("rst_last", last_a, 0);
      chk("rst_sum0", sum_a, 0);
      chk("rst_busy0", busy_a, 0);
      chk("rst_fin", fin_a, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy0", busy_a, 0);

      run_a(0);
      run_a(1);
      run_a(2);
      run_a(3);
      run_a(0);

      start_b = 1'b1; start_c = 1'b1;
      @(negedge clk);
      start_b = 1'b0; start_c = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         chk("b_valid", valid_b, c >= 2 && c <= 5);
         chk("c_valid", valid_c, c >= 2 && c <= 5);
         if (valid_b) begin
            chk("b_data", data_b, 8'hFF);
            chk("b_last", last_b, c == 5);
         end
         if (valid_c) chk("c_data", data_c, exp_c[(c - 2) & 3]);
         chk("b_fin", fin_b, c == 6);
         if (c == 6) begin
            chk("b_sum", sum_b, 16'h03FC);
            chk("c_sum", sum_c, 8'h03);
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
